fetch_ifid: RTL and testbench

Fetch stage plus IF/ID pipeline register. It sits directly upstream of the decode logic that feeds the ID/EX latch.
- Owns the PC and issues instruction-memory reads.
- Tolerates multi-cycle ihit latency.
- Absorbs downstream stalls with a one-entry skid buffer.
- Applies flush/redirect from branch/jump resolution and stops fetching on halt.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/fetch_ifid_if.sv | 50 +++++
 rtl/fetch_ifid_skid.sv | 41 ++++
 rtl/fetch_ifid.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_ifid.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types and constants for the fetch stage.
//   word_t        : 32-bit machine word (instructions and addresses)
//   fetch_state_t : fetch FSM states FETCH / HOLD / HALT
//   NOP_INSTR     : instruction word placed in IF/ID for a bubble
//   PC_STEP       : sequential PC increment in bytes
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;
    localparam word_t PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_ifid_if.sv
// fetch_ifid_if: bundles the fetch stage's instruction-memory bus, the
// pipeline control inputs and the IF/ID outputs.
//   master modport : the fetch stage (drives imemREN/imemaddr and IF/ID)
//   slave modport  : the environment (memory, hazard/branch units, decode)
// Optional macro FETCH_STATS_EN adds fetch_count_o / stall_count_o.
interface fetch_ifid_if;
    import cpu_types_pkg::*;

    // instruction memory bus
    logic  ihit;
    word_t imemload;
    logic  imemREN;
    word_t imemaddr;

    // pipeline control
    logic  stall_i;
    logic  flush_i;
    logic  redirect_i;
    word_t redirect_pc_i;
    logic  halt_i;

    // IF/ID register contents
    word_t instr_o;
    word_t npc_o;
    logic  valid_o;

`ifdef FETCH_STATS_EN
    word_t fetch_count_o;
    word_t stall_count_o;

    modport master (
        input  ihit, imemload, stall_i, flush_i, redirect_i, redirect_pc_i, halt_i,
        output imemREN, imemaddr, instr_o, npc_o, valid_o, fetch_count_o, stall_count_o
    );
    modport slave (
        output ihit, imemload, stall_i, flush_i, redirect_i, redirect_pc_i, halt_i,
        input  imemREN, imemaddr, instr_o, npc_o, valid_o, fetch_count_o, stall_count_o
    );
`else
    modport master (
        input  ihit, imemload, stall_i, flush_i, redirect_i, redirect_pc_i, halt_i,
        output imemREN, imemaddr, instr_o, npc_o, valid_o
    );
    modport slave (
        output ihit, imemload, stall_i, flush_i, redirect_i, redirect_pc_i, halt_i,
        input  imemREN, imemaddr, instr_o, npc_o, valid_o
    );
`endif

endinterface

// File: rtl/fetch_ifid_skid.sv
// fetch_skid: one-entry skid buffer holding {instr, npc} for an instruction
// that returned from memory while IF/ID was stalled.
//   CLK, nRST         : clock, asynchronous active-low reset
//   load_i            : capture instr_i/npc_i, set full
//   drain_i           : entry consumed by IF/ID, clear full
//   clear_i           : discard entry (flush/halt/redirect), wins over load
//   instr_i, npc_i    : entry data in
//   full_o            : entry holds a real instruction
//   instr_q, npc_q    : entry data out
module fetch_skid
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load_i,
    input  logic  drain_i,
    input  logic  clear_i,
    input  word_t instr_i,
    input  word_t npc_i,
    output logic  full_o,
    output word_t instr_q,
    output word_t npc_q
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            full_o  <= 1'b0;
            instr_q <= NOP_INSTR;
            npc_q   <= '0;
        end else if (clear_i || drain_i) begin
            full_o  <= 1'b0;
            instr_q <= NOP_INSTR;
            npc_q   <= '0;
        end else if (load_i) begin
            full_o  <= 1'b1;
            instr_q <= instr_i;
            npc_q   <= npc_i;
        end
    end

endmodule

// File: rtl/fetch_ifid.sv
// fetch_ifid: fetch stage plus IF/ID pipeline register.
// Owns the PC, issues instruction reads, tolerates multi-cycle ihit latency,
// absorbs downstream stalls in a one-entry skid buffer, applies
// flush/redirect and stops fetching on halt.
// Ports:
//   CLK, nRST : clock, asynchronous active-low reset
//   fif       : fetch_ifid_if.master (imem bus, control inputs, IF/ID outputs)
// Parameters:
//   PC_INIT   : PC loaded at reset
//   WORD_W    : word width, fixed at 32
// Optional macro FETCH_STATS_EN adds saturating fetch/stall counters.
module fetch_ifid
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter int    WORD_W  = 32
)
(
    input logic          CLK,
    input logic          nRST,
    fetch_ifid_if.master fif
);

    fetch_state_t      state_p0, state_nxt;
    logic [WORD_W-1:0] pc_p0, pc_nxt;
    logic              rdp_p0, rdp_nxt;      // redirect waiting for ihit
    word_t             rdt_p0, rdt_nxt;      // latched redirect target
    logic              hpend_p0, hpend_nxt;  // halt waiting for ihit

    word_t instr_p1;
    word_t npc_p1;
    logic  vld_p1;

    word_t seq_pc;
    logic  ld_new, ld_buf, ld_bub;
    logic  skid_load, skid_drain, skid_clear;
    logic  skid_full;
    word_t skid_instr, skid_npc;

    fetch_skid u_skid (
        .CLK     (CLK),
        .nRST    (nRST),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .instr_i (fif.imemload),
        .npc_i   (seq_pc),
        .full_o  (skid_full),
        .instr_q (skid_instr),
        .npc_q   (skid_npc)
    );

    assign seq_pc = pc_p0 + PC_STEP;

    always_comb begin
        state_nxt  = state_p0;
        pc_nxt     = pc_p0;
        rdp_nxt    = rdp_p0;
        rdt_nxt    = rdt_p0;
        hpend_nxt  = hpend_p0;
        ld_new     = 1'b0;
        ld_buf     = 1'b0;
        ld_bub     = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;

        unique case (state_p0)
            FETCH: begin
                if (fif.halt_i || hpend_p0) begin
                    // The outstanding read must complete before going idle;
                    // its data is discarded.
                    ld_bub     = 1'b1;
                    skid_clear = 1'b1;
                    rdp_nxt    = 1'b0;
                    if (fif.ihit) begin
                        state_nxt = HALT;
                        hpend_nxt = 1'b0;
                    end else begin
                        hpend_nxt = 1'b1;
                    end
                end else if (fif.ihit) begin
                    if (fif.redirect_i || rdp_p0) begin
                        // Wrong-path instruction: drop it and refetch.
                        pc_nxt  = fif.redirect_i ? fif.redirect_pc_i : rdt_p0;
                        rdp_nxt = 1'b0;
                        ld_bub  = fif.flush_i || !fif.stall_i;
                    end else begin
                        pc_nxt = seq_pc;
                        if (fif.flush_i) begin
                            ld_bub = 1'b1;
                        end else if (fif.stall_i) begin
                            skid_load = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            ld_new = 1'b1;
                        end
                    end
                end else begin
                    // Address must stay stable until ihit, so a redirect
                    // arriving mid-request is parked until then.
                    if (fif.redirect_i) begin
                        rdp_nxt = 1'b1;
                        rdt_nxt = fif.redirect_pc_i;
                    end
                    ld_bub = fif.flush_i || !fif.stall_i;
                end
            end
            HOLD: begin
                if (fif.halt_i) begin
                    ld_bub     = 1'b1;
                    skid_clear = 1'b1;
                    rdp_nxt    = 1'b0;
                    state_nxt  = HALT;
                end else if (fif.flush_i) begin
                    ld_bub     = 1'b1;
                    skid_clear = 1'b1;
                    state_nxt  = FETCH;
                    if (fif.redirect_i) pc_nxt = fif.redirect_pc_i;
                end else if (fif.redirect_i) begin
                    // No read in flight here, so the target applies at once.
                    pc_nxt     = fif.redirect_pc_i;
                    skid_clear = 1'b1;
                    state_nxt  = FETCH;
                    ld_bub     = !fif.stall_i;
                end else if (!fif.stall_i) begin
                    ld_buf     = skid_full;
                    ld_bub     = !skid_full;
                    skid_drain = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_p0 <= FETCH;
            pc_p0    <= PC_INIT;
            rdp_p0   <= 1'b0;
            rdt_p0   <= '0;
            hpend_p0 <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            pc_p0    <= pc_nxt;
            rdp_p0   <= rdp_nxt;
            rdt_p0   <= rdt_nxt;
            hpend_p0 <= hpend_nxt;
        end
    end

    // IF/ID register boundary
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_p1 <= NOP_INSTR;
            npc_p1   <= '0;
            vld_p1   <= 1'b0;
        end else if (ld_new) begin
            instr_p1 <= fif.imemload;
            npc_p1   <= seq_pc;
            vld_p1   <= 1'b1;
        end else if (ld_buf) begin
            instr_p1 <= skid_instr;
            npc_p1   <= skid_npc;
            vld_p1   <= 1'b1;
        end else if (ld_bub) begin
            instr_p1 <= NOP_INSTR;
            npc_p1   <= '0;
            vld_p1   <= 1'b0;
        end
    end

    assign fif.imemREN  = nRST && (state_p0 == FETCH);
    assign fif.imemaddr = (state_p0 == HALT) ? '0 : pc_p0;
    assign fif.instr_o  = instr_p1;
    assign fif.npc_o    = npc_p1;
    assign fif.valid_o  = vld_p1;

`ifdef FETCH_STATS_EN
    word_t fcnt_p1, scnt_p1;

    function automatic word_t sat_inc(input word_t v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fcnt_p1 <= '0;
            scnt_p1 <= '0;
        end else begin
            if (ld_new || ld_buf)       fcnt_p1 <= sat_inc(fcnt_p1);
            if (fif.stall_i && vld_p1)  scnt_p1 <= sat_inc(scnt_p1);
        end
    end

    assign fif.fetch_count_o = fcnt_p1;
    assign fif.stall_count_o = scnt_p1;
`endif

endmodule

// File: tb/tb_fetch_ifid.sv
// tb_fetch_ifid: table-driven bench for fetch_ifid with a scoreboard queue
// of expected IF/ID contents, plus hand-written reset and halt sequences.
module tb_fetch_ifid;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   errors;
    int   checks;

    fetch_ifid_if fif ();

    fetch_ifid #(.PC_INIT(32'h0000_0000), .WORD_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .fif  (fif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        ihit;
        logic [31:0] load;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic        halt;
        logic        ren;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] npc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic void add(input logic ih, input logic [31:0] ld,
                                input logic st, input logic fl, input logic rd,
                                input logic [31:0] rp, input logic hl,
                                input logic en, input logic [31:0] ad,
                                input logic v, input logic [31:0] ins,
                                input logic [31:0] np);
        vec_t e;
        e.ihit = ih; e.load = ld; e.stall = st; e.flush = fl; e.redir = rd;
        e.rpc = rp; e.halt = hl; e.ren = en; e.addr = ad; e.vld = v;
        e.instr = ins; e.npc = np;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fif.ihit          = v.ihit;
        fif.imemload      = v.load;
        fif.stall_i       = v.stall;
        fif.flush_i       = v.flush;
        fif.redirect_i    = v.redir;
        fif.redirect_pc_i = v.rpc;
        fif.halt_i        = v.halt;
    endtask

    // Drive one cycle, check request outputs before the edge, and check the
    // IF/ID contents just after the edge through the scoreboard.
    task automatic run_vec(input vec_t v, input int idx);
        exp_t e, got;
        drive(v);
        #3;
        chk("imemREN", idx, {31'b0, fif.imemREN}, {31'b0, v.ren});
        chk("imemaddr", idx, fif.imemaddr, v.addr);
        e.idx = idx; e.vld = v.vld; e.instr = v.instr; e.npc = v.npc;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard[%0d]: got empty queue expected entry", idx);
        end else begin
            got = sb.pop_front();
            chk("valid_o", got.idx, {31'b0, fif.valid_o}, {31'b0, got.vld});
            chk("instr_o", got.idx, fif.instr_o, got.instr);
            if (got.vld) chk("npc_o", got.idx, fif.npc_o, got.npc);
        end
    endtask

    initial begin
        vec_t z;
        errors = 0;
        checks = 0;

        // c1..c3 streaming
        add(1, 32'h11, 0, 0, 0, 0, 0, 1, 32'h0, 1, 32'h11, 32'h4);
        add(1, 32'h22, 0, 0, 0, 0, 0, 1, 32'h4, 1, 32'h22, 32'h8);
        add(1, 32'h33, 0, 0, 0, 0, 0, 1, 32'h8, 1, 32'h33, 32'hC);
        // c4..c6 three-cycle ihit latency at 0xC
        for (int i = 0; i < 3; i++)
            add(0, 32'hBAD, 0, 0, 0, 0, 0, 1, 32'hC, 0, 32'h0, 32'h0);
        add(1, 32'h44, 0, 0, 0, 0, 0, 1, 32'hC, 1, 32'h44, 32'h10);
        // c8..c10 two-cycle stall with 0x55 parked in the skid buffer
        add(1, 32'h55, 1, 0, 0, 0, 0, 1, 32'h10, 1, 32'h44, 32'h10);
        add(1, 32'hEE, 1, 0, 0, 0, 0, 0, 32'h14, 1, 32'h44, 32'h10);
        add(0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h14, 1, 32'h55, 32'h14);
        // c11..c13 redirect+flush while the read at 0x14 is outstanding
        add(0, 32'h0,    0, 1, 1, 32'h100, 0, 1, 32'h14, 0, 32'h0, 32'h0);
        add(0, 32'h0,    0, 0, 0, 32'h0,   0, 1, 32'h14, 0, 32'h0, 32'h0);
        add(1, 32'hDEAD, 0, 0, 0, 32'h0,   0, 1, 32'h14, 0, 32'h0, 32'h0);
        add(1, 32'h66,   0, 0, 0, 32'h0,   0, 1, 32'h100, 1, 32'h66, 32'h104);
        // c15..c16 stall into HOLD, then flush out of HOLD
        add(1, 32'h77, 1, 0, 0, 0, 0, 1, 32'h104, 1, 32'h66, 32'h104);
        add(0, 32'h0,  1, 1, 0, 0, 0, 0, 32'h108, 0, 32'h0, 32'h0);
        add(1, 32'h88, 0, 0, 0, 0, 0, 1, 32'h108, 1, 32'h88, 32'h10C);
        // c18..c20 redirect on ihit to the top word, then PC wrap
        add(1, 32'h99, 0, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'h10C, 0, 32'h0, 32'h0);
        add(1, 32'hAA, 0, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC, 1, 32'hAA, 32'h0);
        add(1, 32'hBB, 0, 0, 0, 32'h0, 0, 1, 32'h0, 1, 32'hBB, 32'h4);
        // c21..c23 halt with a read in flight: finish it, drop data
        add(0, 32'h0,  0, 0, 0, 0, 1, 1, 32'h4, 0, 32'h0, 32'h0);
        add(0, 32'h0,  0, 0, 0, 0, 1, 1, 32'h4, 0, 32'h0, 32'h0);
        add(1, 32'hCC, 0, 0, 0, 0, 1, 1, 32'h4, 0, 32'h0, 32'h0);
        // HALT must ignore everything
        for (int i = 0; i < 20; i++)
            add(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                1'($urandom_range(0, 1)), 0, 32'h0, 0, 32'h0, 32'h0);

        z = '{ihit: 0, load: 0, stall: 0, flush: 0, redir: 0, rpc: 0, halt: 0,
              ren: 0, addr: 0, vld: 0, instr: 0, npc: 0};
        drive(z);
        nRST = 1'b0;
        #2;
        chk("rst_imemREN", 0, {31'b0, fif.imemREN}, 32'h0);
        chk("rst_imemaddr", 0, fif.imemaddr, 32'h0);
        chk("rst_valid", 0, {31'b0, fif.valid_o}, 32'h0);
        chk("rst_instr", 0, fif.instr_o, 32'h0);
        chk("rst_npc", 0, fif.npc_o, 32'h0);
`ifdef FETCH_STATS_EN
        chk("rst_fetch_count", 0, fif.fetch_count_o, 32'h0);
        chk("rst_stall_count", 0, fif.stall_count_o, 32'h0);
`endif
        @(posedge CLK);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], i);
`ifdef FETCH_STATS_EN
            if (i == 9) chk("stall_count_after_stall", i, fif.stall_count_o, 32'd2);
`endif
        end
`ifdef FETCH_STATS_EN
        chk("fetch_count_table", 0, fif.fetch_count_o, 32'd9);
        chk("stall_count_table", 0, fif.stall_count_o, 32'd4);
`endif

        // Reset from HALT, load one instruction, then reset mid-request.
        drive(z);
        nRST = 1'b0;
        #1;
        chk("rst2_imemaddr", 100, fif.imemaddr, 32'h0);
        chk("rst2_imemREN", 100, {31'b0, fif.imemREN}, 32'h0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        z.ihit = 1; z.load = 32'h12; z.ren = 1; z.addr = 32'h0;
        z.vld = 1; z.instr = 32'h12; z.npc = 32'h4;
        run_vec(z, 101);
        fif.ihit = 1'b0;
        #2;
        chk("inflight_addr", 102, fif.imemaddr, 32'h4);
        nRST = 1'b0;
        #1;
        chk("midrst_valid", 102, {31'b0, fif.valid_o}, 32'h0);
        chk("midrst_instr", 102, fif.instr_o, 32'h0);
        chk("midrst_npc", 102, fif.npc_o, 32'h0);
        chk("midrst_imemREN", 102, {31'b0, fif.imemREN}, 32'h0);
        chk("midrst_imemaddr", 102, fif.imemaddr, 32'h0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        // late ihit is taken as the response for PC_INIT
        z.ihit = 1; z.load = 32'h34; z.ren = 1; z.addr = 32'h0;
        z.vld = 1; z.instr = 32'h34; z.npc = 32'h4;
        run_vec(z, 103);
        // halt with the read completing this cycle: HALT on the next edge
        z.ihit = 1; z.load = 32'h56; z.halt = 1; z.ren = 1; z.addr = 32'h4;
        z.vld = 0; z.instr = 32'h0; z.npc = 32'h0;
        run_vec(z, 104);
        for (int i = 0; i < 20; i++) begin
            z.ihit = 1'($urandom_range(0, 1)); z.load = $urandom;
            z.stall = 1'($urandom_range(0, 1)); z.flush = 1'($urandom_range(0, 1));
            z.redir = 1'($urandom_range(0, 1)); z.rpc = $urandom;
            z.halt = 1'($urandom_range(0, 1));
            z.ren = 0; z.addr = 32'h0; z.vld = 0; z.instr = 32'h0;
            run_vec(z, 105 + i);
        end
`ifdef FETCH_STATS_EN
        chk("fetch_count_seq", 200, fif.fetch_count_o, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
